// File: rtl/light_monitor.sv
// light_monitor
//   Receive-side checker for the traffic light controller's ASCII lamp buses.
//   Each direction's 6-character lamp string is decoded into a one-hot lamp
//   drive and tracked by its own phase FSM. The block flags illegal phase
//   transitions, yellow phases that are too short, undecodable strings and
//   A/B right-of-way conflicts. A saturating counter records error cycles.
//
// Ports
//   i_clk      : system clock, rising edge
//   i_rstn     : asynchronous active-low reset
//   i_la, i_lb : lamp strings for directions A and B (8-bit ASCII, MSB byte first)
//   o_lamp_a/b : one-hot lamp drive {R,Y,G}
//   o_dwell_a/b: cycles the direction has held its current phase (saturating)
//   o_conflict : level, both directions non-RED
//   o_invalid  : pulse, at least one input string is not a legal code
//   o_seq_err  : pulse, illegal transition or short yellow on either direction
//   o_err_cnt  : saturating count of cycles with any error flag set
//
// All outputs are registered: the sample taken at edge k shows after edge k.
module light_monitor #(
  parameter int MIN_YELLOW = 2,
  parameter int DW         = 8,
  parameter int EW         = 8
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic [47:0]   i_la,
  input  logic [47:0]   i_lb,
  output logic [2:0]    o_lamp_a,
  output logic [2:0]    o_lamp_b,
  output logic [DW-1:0] o_dwell_a,
  output logic [DW-1:0] o_dwell_b,
  output logic          o_conflict,
  output logic          o_invalid,
  output logic          o_seq_err,
  output logic [EW-1:0] o_err_cnt
);

  typedef enum logic [1:0] {UNK, GRN, YEL, RED} phase_t;

  localparam logic [47:0] CODE_GREEN  = "GREEN ";
  localparam logic [47:0] CODE_YELLOW = "YELLOW";
  localparam logic [47:0] CODE_RED    = "RED   ";

  localparam logic [2:0]    LAMP_RED  = 3'b100;
  localparam logic [DW-1:0] DWELL_MAX = {DW{1'b1}};
  localparam logic [DW-1:0] MIN_Y     = DW'(MIN_YELLOW);

  // Direction A occupies slot 0, direction B slot 1.
  logic [95:0]     code_all;
  logic [5:0]      lamp_all;
  logic [5:0]      lamp_next_all;
  logic [2*DW-1:0] dwell_all;
  logic [1:0]      inv_all;
  logic [1:0]      seq_all;

  assign code_all = {i_lb, i_la};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dir
      logic [47:0]   code_in;
      logic [2:0]    code;
      phase_t        new_ph;
      phase_t        state_reg, state_next;
      logic [2:0]    lamp_reg, lamp_next;
      logic [DW-1:0] dwell_reg, dwell_next;
      logic          inv, seq;

      assign code_in = code_all[gi*48 +: 48];

      // Exact 48-bit match only; anything else decodes to 3'b000.
      always_comb begin
        code   = 3'b000;
        new_ph = UNK;
        case (code_in)
          CODE_GREEN:  begin code = 3'b001; new_ph = GRN; end
          CODE_YELLOW: begin code = 3'b010; new_ph = YEL; end
          CODE_RED:    begin code = 3'b100; new_ph = RED; end
          default:     begin code = 3'b000; new_ph = UNK; end
        endcase
      end

      always_comb begin
        state_next = state_reg;
        lamp_next  = lamp_reg;
        dwell_next = dwell_reg;
        inv        = 1'b0;
        seq        = 1'b0;
        if (code == 3'b000) begin
          // Undecodable string: freeze this direction entirely.
          inv = 1'b1;
        end else begin
          // Even on an illegal step the FSM follows the input so that it
          // resynchronises to what the controller is actually showing.
          state_next = new_ph;
          lamp_next  = code;
          if (new_ph != state_reg) begin
            dwell_next = DW'(1);
          end else if (dwell_reg != DWELL_MAX) begin
            dwell_next = dwell_reg + DW'(1);
          end
          case (state_reg)
            GRN:     seq = (new_ph == RED);
            YEL:     seq = (new_ph == GRN) || ((new_ph == RED) && (dwell_reg < MIN_Y));
            RED:     seq = (new_ph == YEL);
            default: seq = 1'b0;  // first valid sample after UNK is unchecked
          endcase
        end
      end

      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
          state_reg <= UNK;
          lamp_reg  <= LAMP_RED;
          dwell_reg <= '0;
        end else begin
          state_reg <= state_next;
          lamp_reg  <= lamp_next;
          dwell_reg <= dwell_next;
        end
      end

      assign lamp_all[gi*3 +: 3]       = lamp_reg;
      assign lamp_next_all[gi*3 +: 3]  = lamp_next;
      assign dwell_all[gi*DW +: DW]    = dwell_reg;
      assign inv_all[gi]               = inv;
      assign seq_all[gi]               = seq;
    end
  endgenerate

  assign o_lamp_a  = lamp_all[2:0];
  assign o_lamp_b  = lamp_all[5:3];
  assign o_dwell_a = dwell_all[DW-1:0];
  assign o_dwell_b = dwell_all[2*DW-1:DW];

  logic conflict_next;
  logic invalid_next;
  logic seq_err_next;
  logic any_err;

  // Conflict is judged on the lamps as they will be after this update.
  assign conflict_next = !lamp_next_all[2] && !lamp_next_all[5];
  assign invalid_next  = |inv_all;
  assign seq_err_next  = |seq_all;
  assign any_err       = conflict_next | invalid_next | seq_err_next;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_conflict <= 1'b0;
      o_invalid  <= 1'b0;
      o_seq_err  <= 1'b0;
      o_err_cnt  <= '0;
    end else begin
      o_conflict <= conflict_next;
      o_invalid  <= invalid_next;
      o_seq_err  <= seq_err_next;
      // Several simultaneous events still count as a single error cycle.
      if (any_err && (o_err_cnt != {EW{1'b1}})) begin
        o_err_cnt <= o_err_cnt + EW'(1);
      end
    end
  end

endmodule

// File: doc/light_monitor.md
Name: light_monitor

Overview:
- Receive-side consumer of the traffic light controller's ASCII lamp buses: decodes each 6-character lamp string into one-hot lamp drives and checks the light sequence.
- Sits between the light FSM outputs and the lamp drivers/status logic.
- Tracks each direction with its own phase FSM and flags illegal transitions, short yellow phases, invalid codes and A/B right-of-way conflicts.
- Keeps a saturating error counter.

Parameters:
- MIN_YELLOW, 2: minimum consecutive cycles a direction must stay YELLOW before RED is legal.
- DW, 8: width of the dwell counters.
- EW, 8: width of the error counter.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rstn  input  1  asynchronous active-low reset.
- i_la  input  48  direction A lamp string, 8-bit ASCII, MSB byte first.
- i_lb  input  48  direction B lamp string, same format.
- o_lamp_a  output  3  direction A lamp drive {R,Y,G}, one-hot.
- o_lamp_b  output  3  direction B lamp drive {R,Y,G}, one-hot.
- o_dwell_a  output  DW  cycles A has held its current phase, saturating.
- o_dwell_b  output  DW  cycles B has held its current phase, saturating.
- o_conflict  output  1  level: A and B are both non-RED.
- o_invalid  output  1  pulse: an input string is not a legal code.
- o_seq_err  output  1  pulse: illegal transition or short yellow.
- o_err_cnt  output  EW  saturating count of error cycles.

Behaviour:
- Legal codes (exact 48-bit match, space padded):
  - "GREEN " → 3'b001
  - "YELLOW" → 3'b010
  - "RED   " → 3'b100
  - Every other value is invalid.
- Clock and reset:
  - One clock domain; reset asynchronous, active-low.
  - All outputs are registered.
- Reset values:
  - o_lamp_a and o_lamp_b = 3'b100 (fail-safe RED).
  - Dwell counters = 0.
  - o_conflict, o_invalid, o_seq_err = 0; o_err_cnt = 0.
  - Both phase FSMs = UNK.
- Latency: inputs are sampled at rising edge k; all outputs reflect that sample after edge k (1-cycle latency).
- Per-direction phase FSM, states UNK, GRN, YEL, RED:
  - From UNK, the first valid code enters the matching state with no check.
  - Legal: GRN→GRN, GRN→YEL, YEL→YEL, YEL→RED, RED→RED, RED→GRN.
  - Illegal: GRN→RED, YEL→GRN, RED→YEL. The FSM still moves to the new state (it resynchronises), the lamp shows the new code, and o_seq_err pulses.
  - YEL→RED with dwell (cycles already in YEL, counting the entry cycle as 1) < MIN_YELLOW also pulses o_seq_err.
- Invalid code on a direction:
  - o_invalid pulses.
  - That direction's FSM, lamp and dwell are held (the dwell counter does not increment).
  - The other direction is processed normally.
- Dwell counter:
  - Set to 1 on a state change, including the first entry from UNK.
  - Otherwise increments by 1 per valid same-state sample.
  - Saturates at 2^DW-1 with no wrap.
- o_conflict = 1 when, after the update, neither o_lamp_a nor o_lamp_b is RED (covers GRN/GRN, GRN/YEL, YEL/YEL).
- o_err_cnt:
  - Increments by exactly 1 in any cycle where o_seq_err, o_invalid or o_conflict is asserted.
  - Simultaneous events in the same cycle still count once.
  - Saturates at 2^EW-1.
- Error pulses: simultaneous errors on A and B assert o_seq_err for one cycle only.
- Reset mid-operation: all state returns immediately (asynchronously) to the reset values. The first valid sample after reset is unchecked.

Test Plan:
1. Reset → lamps 3'b100/3'b100, dwell 0/0, all flags 0, o_err_cnt 0. Assert i_rstn low mid-run → same values immediately, before the next edge.
2. Legal cycle on A: GREEN×3, YELLOW×2, RED×4, GREEN; B held at RED →
   - o_lamp_a follows one cycle later;
   - o_dwell_a reaches 3, 2, 4, then 1;
   - no flags; o_err_cnt stays 0.
3. Illegal and short-yellow transitions on A (B RED), MIN_YELLOW=2:
   - A: GREEN → RED → one o_seq_err pulse; lamp shows 3'b100.
   - A: GREEN → YELLOW×1 → RED → one o_seq_err pulse on the RED sample.
   - o_err_cnt ends at 2.
4. Invalid code: A=GREEN for 2 cycles, then A="BLUE  " for 3 cycles →
   - o_invalid high 3 cycles;
   - o_lamp_a held at 3'b001 and o_dwell_a held at 2;
   - o_err_cnt +3;
   - next GREEN gives dwell 3.
5. Conflict: A=GREEN, B=YELLOW for 2 cycles → o_conflict high 2 cycles, o_err_cnt +2. Also apply an invalid A code and an illegal B transition in the same cycle → o_err_cnt +1 only.
6. Saturation with DW=4, EW=4:
   - hold A GREEN for 20 cycles → o_dwell_a stops at 15;
   - 20 conflict cycles → o_err_cnt stops at 15 with no wrap.
